// File: rtl/parity_frame_rx_if.sv
// Bus bundle for the parity-protected serial frame receiver.
// Handshake: rx_valid is a one-cycle strobe with no ready/backpressure.
// The consumer must take rx_data, parity_err and frame_err on the cycle
// rx_valid is high; the receiver cannot be stalled. The three values then
// hold until the next completed frame.
interface parity_frame_rx_if #(
  parameter int DATA_W    = 10,
  parameter int ERR_CNT_W = 8
);
  logic                 rx_in;
  logic                 clr_count;
  logic [DATA_W-1:0]    rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 busy;

  // Line and control side (pad / testbench).
  modport master (
    output rx_in,
    output clr_count,
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  err_count,
    input  busy
  );

  // Receiver side.
  modport slave (
    input  rx_in,
    input  clr_count,
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output err_count,
    output busy
  );
endinterface

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, even-parity
// bit, stop bit. Presents the word with parity/stop error flags and keeps a
// saturating count of bad frames. The line is asynchronous and is brought in
// through a 2-FF synchroniser; all sampling is done on the synchronised value.
module parity_frame_rx #(
  parameter int DATA_W       = 10,
  parameter int CLKS_PER_BIT = 4,
  parameter int ERR_CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  parity_frame_rx_if.slave  bus,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  localparam int TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // Timer terminal values: half a bit for the start-bit centre check, a full
  // bit period for every later sample.
  localparam logic [TMR_W-1:0]     HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0]     FULL_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0]     TMR_ONE   = TMR_W'(1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX   = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE   = ERR_CNT_W'(1);

  state_t               state;
  logic                 sync_1;
  logic                 rx_s;
  logic [TMR_W-1:0]     timer;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_W-1:0]    shift;
  logic                 par_bit;

  logic [DATA_W-1:0]    rx_data_q;
  logic                 rx_valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic                 stop_sample;
  logic                 parity_err_next;
  logic                 frame_err_next;

  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= bus.rx_in;
      rx_s   <= sync_1;
    end
  end

  // Frame-completion terms, shared by the FSM outputs and the error counter.
  assign stop_sample     = (state == STOP) && (timer == FULL_LAST);
  assign parity_err_next = par_bit ^ (^shift);
  assign frame_err_next  = ~rx_s;

  // Receive FSM with bit timer, shift register and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      par_bit      <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end
        START: begin
          if (timer == HALF_LAST) begin
            timer   <= '0;
            bit_idx <= '0;
            // A line back high at mid-start is a glitch: drop it silently.
            state   <= rx_s ? IDLE : DATA;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        DATA: begin
          if (timer == FULL_LAST) begin
            timer <= '0;
            // Shifting in from the top leaves the first bit in position 0.
            shift <= {rx_s, shift[DATA_W-1:1]};
            if (bit_idx == IDX_LAST) begin
              state <= PARITY;
            end else begin
              bit_idx <= bit_idx + IDX_ONE;
            end
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        PARITY: begin
          if (timer == FULL_LAST) begin
            timer   <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        STOP: begin
          if (timer == FULL_LAST) begin
            timer        <= '0;
            rx_valid_q   <= 1'b1;
            rx_data_q    <= shift;
            parity_err_q <= parity_err_next;
            frame_err_q  <= frame_err_next;
            // A low stop bit may be a line break; wait for the line to
            // return high before hunting for the next start bit.
            state        <= rx_s ? IDLE : WAIT_IDLE;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        WAIT_IDLE: begin
          timer <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Saturating bad-frame counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (bus.clr_count) begin
      err_count_q <= '0;
    end else if (stop_sample && (parity_err_next || frame_err_next) &&
                 (err_count_q != CNT_MAX)) begin
      err_count_q <= err_count_q + CNT_ONE;
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_count  = err_count_q;
  assign bus.busy       = (state != IDLE);
  assign dbg_state      = state;

endmodule
